// File: rtl/mips_seq_pkg.sv
// mips_seq_pkg: shared state encoding, HLT opcode and default widths for the test sequencer
package mips_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;
  localparam logic [5:0] HLT_OP = 6'b111111;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_AW = 10;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/mips_seq_ctr.sv
// mips_seq_ctr: load-zero/increment address counter with terminal-count compare
module mips_seq_ctr #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == term_i;
endmodule

// File: rtl/mips_test_sequencer.sv
// mips_test_sequencer: clear regs, load program, run core to HLT or cycle limit, dump regs
module mips_test_sequencer
  import mips_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int NREGS  = DEF_NREGS,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW:0]   prog_len,
  input  logic [CNT_W-1:0]  max_cycles,
  output logic [MEM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              core_hold,
  output logic              core_pc_clr,
  input  logic              core_halted,
  output logic              dump_valid,
  output logic [REG_AW-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int W = (MEM_AW > REG_AW ? MEM_AW : REG_AW) + 1;
  state_t state_q, state_d;
  logic [W-1:0] ctr, term;
  logic tc, go, run_hit, run_to, first_q, to_q, to_d, ld_v_q, dv_q;
  logic [MEM_AW:0] len_q;
  logic [CNT_W-1:0] mc_q, cnt_q, cnt_d;
  logic [MEM_AW-1:0] ld_a_q;
  logic [REG_AW-1:0] di_q;
  assign go      = start && (state_q == S_IDLE || state_q == S_DONE);
  // the halted flag is stale from the previous run during the pc_clr cycle
  assign run_hit = !first_q && core_halted;
  assign run_to  = mc_q != '0 && cnt_q == mc_q - 1'b1;
  assign term    = state_q == S_CLEAR ? W'(NREGS - 1) : state_q == S_LOAD ? W'(len_q) : W'(NREGS);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = go ? S_CLEAR : state_q;
      S_CLEAR:        state_d = tc ? (len_q == '0 ? S_RUN : S_LOAD) : S_CLEAR;
      S_LOAD:         state_d = tc ? S_RUN : S_LOAD;
      S_RUN:          state_d = (run_hit || run_to) ? S_DUMP : S_RUN;
      S_DUMP:         state_d = tc ? S_DONE : S_DUMP;
      default:        state_d = S_IDLE;
    endcase
  end
  assign cnt_d = go ? '0 : (state_q == S_RUN && state_d == S_RUN && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign to_d  = go ? 1'b0 : (state_q == S_RUN && state_d == S_DUMP) ? !run_hit : to_q;
  mips_seq_ctr #(.W(W)) u_ctr (
    .clk    (clk1),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .inc_i  (state_q == S_CLEAR || state_q == S_LOAD || state_q == S_DUMP),
    .term_i (term),
    .cnt_o  (ctr),
    .tc_o   (tc)
  );
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      first_q <= 1'b0;
      ld_v_q  <= 1'b0;
      ld_a_q  <= '0;
      dv_q    <= 1'b0;
      di_q    <= '0;
      len_q   <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      first_q <= state_q != S_RUN && state_d == S_RUN;
      ld_v_q  <= state_q == S_LOAD && ctr < W'(len_q);
      ld_a_q  <= ctr[MEM_AW-1:0];
      dv_q    <= state_q == S_DUMP && !tc;
      di_q    <= ctr[REG_AW-1:0];
      if (go) begin
        len_q <= prog_len;
        mc_q  <= max_cycles;
      end
    end
  end
  assign rom_addr    = ctr[MEM_AW-1:0];
  assign mem_we      = ld_v_q;
  assign mem_addr    = ld_a_q;
  assign mem_wdata   = ld_v_q ? rom_data : '0;
  assign reg_we      = state_q == S_CLEAR;
  assign reg_waddr   = ctr[REG_AW-1:0];
  assign reg_raddr   = ctr[REG_AW-1:0];
  assign core_hold   = state_q != S_RUN;
  assign core_pc_clr = state_q == S_RUN && first_q;
  assign dump_valid  = dv_q;
  assign dump_idx    = di_q;
  assign dump_data   = dv_q ? reg_rdata : '0;
  assign busy        = state_q != S_IDLE && state_q != S_DONE;
  assign done        = state_q == S_DONE;
  assign timeout     = to_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_mips_test_sequencer.sv
// tb_mips_test_sequencer: table-driven runs against ROM/imem/regfile/core models
module tb_mips_test_sequencer;
  import mips_seq_pkg::*;
  logic clk1 = 1'b0, rst = 1'b1, start = 1'b0;
  logic [10:0] prog_len = '0;
  logic [15:0] max_cycles = '0;
  logic [9:0] rom_addr, mem_addr;
  logic [31:0] rom_data = '0, mem_wdata, reg_rdata = '0, dump_data;
  logic mem_we, reg_we, core_hold, core_pc_clr, dump_valid, busy, done, timeout;
  logic [4:0] reg_waddr, reg_raddr, dump_idx;
  logic [15:0] cycle_count;
  logic [31:0] rom [1024] = '{default: '0};
  logic [31:0] imem [1024] = '{default: '0};
  logic [31:0] regs [32] = '{default: '0};
  logic [31:0] dlog [32] = '{default: '0};
  logic [9:0] pc = '0;
  logic halted = 1'b0;
  int n_tests = 0, n_fail = 0;
  int n_regwe = 0, n_memwe = 0, n_dump = 0, n_run = 0, n_pcclr = 0, cbad = 0, mbad = 0, dbad = 0;
  logic [4:0] cseq = '0, dseq = '0;
  logic [9:0] mseq = '0;

  mips_test_sequencer dut (
    .clk1(clk1), .rst(rst), .start(start), .prog_len(prog_len), .max_cycles(max_cycles),
    .rom_addr(rom_addr), .rom_data(rom_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata), .core_hold(core_hold), .core_pc_clr(core_pc_clr),
    .core_halted(halted), .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  // ROM, instruction memory, register file and a toy core that writes regs or halts
  always @(posedge clk1) begin
    rom_data  <= rom[rom_addr];
    reg_rdata <= regs[reg_raddr];
    if (mem_we) imem[mem_addr] <= mem_wdata;
    if (reg_we) regs[reg_waddr] <= '0;
    if (core_pc_clr) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!core_hold && !halted) begin
      if (imem[pc][31:26] == HLT_OP) halted <= 1'b1;
      else regs[imem[pc][4:0]] <= imem[pc];
      pc <= pc + 1'b1;
    end
  end

  always @(negedge clk1) begin
    if (reg_we) begin
      if (reg_waddr != cseq) cbad++;
      cseq = cseq + 1'b1;
      mseq = '0;
      dseq = '0;
      n_regwe++;
    end
    if (mem_we) begin
      if (mem_addr != mseq || mem_wdata != rom[mem_addr]) mbad++;
      mseq = mseq + 1'b1;
      n_memwe++;
    end
    if (dump_valid) begin
      if (dump_idx != dseq || dump_data != regs[dump_idx]) dbad++;
      dlog[dump_idx] = dump_data;
      dseq = dseq + 1'b1;
      n_dump++;
    end
    if (!core_hold) n_run++;
    if (core_pc_clr) n_pcclr++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rom(input bit hlt);
    for (int i = 0; i < 8; i++) rom[i] = 32'h0400_0000 + (32'(i) << 12) + 32'(i + 1);
    rom[8] = hlt ? 32'hFFFF_FFFF : 32'h0400_8009;
  endtask

  typedef struct {
    int plen; int maxc; bit hlt; bit poke; bit chk5; bit eto; int ecc; int erun;
  } vec_t;
  vec_t tbl [6];

  initial begin
    bit found, fin;
    int r0, m0, d0, u0, p0, cb0, mb0, db0;
    tbl[0] = '{9,   0, 1'b1, 1'b0, 1'b1, 1'b0, 10,  11};
    tbl[1] = '{9, 100, 1'b0, 1'b1, 1'b0, 1'b1, 99, 100};
    tbl[2] = '{0,  50, 1'b0, 1'b0, 1'b0, 1'b1, 49,  50};
    tbl[3] = '{9,  11, 1'b1, 1'b0, 1'b1, 1'b0, 10,  11};
    tbl[4] = '{9,  10, 1'b1, 1'b0, 1'b0, 1'b1,  9,  10};
    tbl[5] = '{0,   1, 1'b0, 1'b0, 1'b0, 1'b1,  0,   1};
    repeat (3) @(negedge clk1);
    chk("rst_hold", core_hold, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk1);
    chk("idle_hold", core_hold, 1);
    chk("idle_outs", {busy, done, timeout, mem_we, reg_we, dump_valid, core_pc_clr}, 0);
    chk("idle_cc", cycle_count, 0);
    // reset while the fourth program word is being written
    load_rom(1'b1);
    prog_len = 11'd9;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk1);
      found = mem_we && mem_addr == 10'd3;
    end
    chk("midload_reach", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("midload_we", mem_we, 0);
    chk("midload_hold", core_hold, 1);
    chk("midload_busy", busy, 0);
    m0 = n_memwe;
    r0 = n_regwe;
    @(negedge clk1) rst = 1'b0;
    repeat (20) @(negedge clk1);
    chk("midload_nowr", 64'(n_memwe - m0), 0);
    chk("midload_noclr", 64'(n_regwe - r0), 0);
    chk("midload_idle", {busy, done}, 0);
    for (int k = 0; k < 6; k++) begin
      load_rom(tbl[k].hlt);
      prog_len   = 11'(tbl[k].plen);
      max_cycles = 16'(tbl[k].maxc);
      r0 = n_regwe; m0 = n_memwe; d0 = n_dump; u0 = n_run; p0 = n_pcclr;
      cb0 = cbad; mb0 = mbad; db0 = dbad;
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      chk("start_done", done, 0);
      chk("start_busy", busy, 1);
      chk("start_cc", cycle_count, 0);
      chk("start_to", timeout, 0);
      fin = 1'b0;
      for (int c = 0; c < 3000 && !fin; c++) begin
        @(negedge clk1);
        start = tbl[k].poke && (n_run - u0 == 5);
        fin = done;
      end
      start = 1'b0;
      chk("done_reach", fin, 1);
      @(negedge clk1);
      $display("[TB] run %0d: cc=%0d to=%0d run=%0d", k, cycle_count, timeout, n_run - u0);
      chk("timeout", timeout, 64'(tbl[k].eto));
      chk("cycle_count", cycle_count, 64'(tbl[k].ecc));
      chk("run_cycles", 64'(n_run - u0), 64'(tbl[k].erun));
      chk("pc_clr", 64'(n_pcclr - p0), 1);
      chk("clr_writes", 64'(n_regwe - r0), 32);
      chk("mem_writes", 64'(n_memwe - m0), 64'(tbl[k].plen));
      chk("dump_beats", 64'(n_dump - d0), 32);
      chk("clr_addr", 64'(cbad - cb0), 0);
      chk("mem_data", 64'(mbad - mb0), 0);
      chk("dump_data", 64'(dbad - db0), 0);
      chk("done_held", {done, busy}, 2'b10);
      if (tbl[k].chk5) begin
        chk("dump_r5", dlog[5], 32'h0400_4005);
        chk("dump_r8", dlog[8], 32'h0400_7008);
        chk("dump_r0", dlog[0], 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
